bist_ora_misr: RTL



---
 rtl/bist_ora_misr.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/bist_ora_misr.sv
// BIST output response analyser: compacts {sum,cout} CUT responses into a MISR and
// compares the final signature with a golden value. Optional watchdog: BIST_ORA_TIMEOUT_EN.
module bist_ora_misr #(
    parameter int               SIG_W         = 8,
    parameter logic [SIG_W-1:0] POLY          = 8'h1D,
    parameter logic [SIG_W-1:0] SEED          = 8'h00,
    parameter int               PATTERN_COUNT = 8,
    parameter logic [SIG_W-1:0] GOLDEN_SIG    = 8'hC5,
    parameter int               TIMEOUT       = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               data_valid,
    input  logic [1:0]                         dataIn,
    output logic                               busy,
    output logic                               done,
    output logic                               pass,
    output logic                               fail,
    output logic [SIG_W-1:0]                   signature,
    output logic [$clog2(PATTERN_COUNT):0]     pat_cnt,
    output logic                               timeout
);

    localparam int CNT_W = $clog2(PATTERN_COUNT) + 1;

    typedef enum logic [1:0] {S_IDLE, S_COMPACT, S_COMPARE, S_DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic               w_load;
    logic               w_shift;
    logic               w_cmp;
    logic               w_to;
    logic [SIG_W-1:0]   r_sig;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_pass;
    logic               r_fail;

    // Shift left, fold the MSB back through the taps, then inject the response.
    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s, input logic [1:0] d);
        logic [SIG_W-1:0] fb;
        fb = s[SIG_W-1] ? POLY : '0;
        return ({s[SIG_W-2:0], 1'b0} ^ fb) ^ {{(SIG_W-2){1'b0}}, d};
    endfunction

`ifdef BIST_ORA_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    logic [IDLE_W-1:0]  r_idle;
    logic               r_timeout;
`else
    logic               w_unused_timeout_param;
    assign w_unused_timeout_param = (TIMEOUT > 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_shift = 1'b0;
        w_cmp   = 1'b0;
        w_to    = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_next = S_COMPACT;
                    w_load = 1'b1;
                end
            end
            S_COMPACT: begin
                if (data_valid) begin
                    w_shift = 1'b1;
                    if (r_cnt == CNT_W'(PATTERN_COUNT - 1)) w_next = S_COMPARE;
                end
`ifdef BIST_ORA_TIMEOUT_EN
                else if (r_idle == IDLE_W'(TIMEOUT - 1)) begin
                    w_next = S_DONE;
                    w_to   = 1'b1;
                end
`endif
            end
            S_COMPARE: begin
                w_next = S_DONE;
                w_cmp  = 1'b1;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sig  <= SEED;
            r_cnt  <= '0;
            r_pass <= 1'b0;
            r_fail <= 1'b0;
        end else if (w_load) begin
            r_sig  <= SEED;
            r_cnt  <= '0;
            r_pass <= 1'b0;
            r_fail <= 1'b0;
        end else begin
            if (w_shift) begin
                r_sig <= misr_step(r_sig, dataIn);
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_cmp) begin
                r_pass <= (r_sig == GOLDEN_SIG);
                r_fail <= (r_sig != GOLDEN_SIG);
            end
            if (w_to) begin
                r_pass <= 1'b0;
                r_fail <= 1'b1;
            end
        end
    end

`ifdef BIST_ORA_TIMEOUT_EN
    // Idle watchdog only counts while waiting for responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idle    <= '0;
            r_timeout <= 1'b0;
        end else if (w_load) begin
            r_idle    <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state == S_COMPACT) begin
                if (data_valid) r_idle <= '0;
                else            r_idle <= r_idle + IDLE_W'(1);
            end
            if (w_to) r_timeout <= 1'b1;
        end
    end
    assign timeout = r_timeout;
`else
    assign timeout = 1'b0;
`endif

    assign busy      = (r_state == S_COMPACT) || (r_state == S_COMPARE);
    assign done      = (r_state == S_DONE);
    assign pass      = r_pass;
    assign fail      = r_fail;
    assign signature = r_sig;
    assign pat_cnt   = r_cnt;

endmodule
